igniter_sequencer: RTL

//  Shares one igniter carriage between NUM_REQ candle requesters using round-robin arbitration.
//  For the granted request it issues signed move commands (enable_move/delta) to the igniter.
//  It checks the igniter's position_q after each move. Once the carriage sits on the target slot,
//  it fires a timed spark, then acks the requester.

---
 rtl/igniter_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/igniter_sequencer.sv
// Round-robin sequencer that walks one shared igniter carriage to each requester's slot, sparks, then acks.
// Build option IGN_TIMEOUT_EN: abort a request (ack + err, no spark) after MAX_MOVES move pulses.
module igniter_sequencer #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MAX_STEP      = 7,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SPARK_CYCLES  = 4,
  parameter int unsigned MAX_MOVES     = 8
) (
  input  logic                 sys_clk,
  input  logic                 clr_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [3*NUM_REQ-1:0] req_pos,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic [2:0]           position_q,
  output logic                 enable_move,
  output logic [3:0]           delta,
  output logic                 spark,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 err
);

  localparam int unsigned POS_W = 3;
  localparam int unsigned ID_W  = 3;
  localparam int unsigned DW    = 4;
  localparam int unsigned TMAX  = (SETTLE_CYCLES > SPARK_CYCLES) ? SETTLE_CYCLES : SPARK_CYCLES;
  localparam int unsigned TW    = $clog2(TMAX + 1);
  localparam logic signed [DW-1:0] STEP_P = DW'(MAX_STEP);
  localparam logic signed [DW-1:0] STEP_N = -STEP_P;

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_STEP < 1 || MAX_STEP > 7 ||
      SETTLE_CYCLES < 1 || SPARK_CYCLES < 1 || MAX_MOVES < 1) begin : g_param_check
    $error("igniter_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE   = 3'd1,
    S_SETTLE = 3'd2,
    S_SPARK  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [POS_W-1:0]   tgt_q, tgt_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               busy_q, busy_d;
  logic               spark_q, spark_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

`ifdef IGN_TIMEOUT_EN
  localparam int unsigned MW = $clog2(MAX_MOVES + 1);
  logic [MW-1:0] moves_q, moves_d;
  logic          err_q, err_d;
`endif

  // Round-robin pick: first valid at or above rr_q, otherwise lowest valid (wrap).
  logic             hi_found, lo_found, any_req;
  logic [ID_W-1:0]  hi_pick, lo_pick, pick;
  logic [POS_W-1:0] pick_pos;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (req_valid[j]) begin
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_pick  = ID_W'(j);
        end
        if (!hi_found && (ID_W'(j) >= rr_q)) begin
          hi_found = 1'b1;
          hi_pick  = ID_W'(j);
        end
      end
    end
    pick     = hi_found ? hi_pick : lo_pick;
    any_req  = lo_found;
    pick_pos = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (ID_W'(j) == pick) pick_pos = req_pos[POS_W*j +: POS_W];
    end
  end

  // Signed distance to target, clamped to the per-pulse step limit.
  logic signed [DW-1:0] diff_c, step_c;

  always_comb begin
    diff_c = $signed({1'b0, tgt_q}) - $signed({1'b0, position_q});
    if (diff_c > STEP_P)      step_c = STEP_P;
    else if (diff_c < STEP_N) step_c = STEP_N;
    else                      step_c = diff_c;
  end

  // Next-state and output logic; the move strobe is driven in the MOVE cycle itself.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    tgt_d       = tgt_q;
    tmr_d       = tmr_q;
    enable_move = 1'b0;
    delta       = '0;
`ifdef IGN_TIMEOUT_EN
    moves_d     = moves_q;
    err_d       = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_MOVE;
          grant_d = pick;
          tgt_d   = pick_pos;
          rr_d    = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
`ifdef IGN_TIMEOUT_EN
          moves_d = '0;
`endif
        end
      end
      S_MOVE: begin
        if (diff_c == '0) begin
          state_d = S_SPARK;
          tmr_d   = '0;
        end
`ifdef IGN_TIMEOUT_EN
        else if (moves_q == MW'(MAX_MOVES)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
`endif
        else begin
          enable_move = 1'b1;
          delta       = step_c;
          state_d     = S_SETTLE;
          tmr_d       = '0;
`ifdef IGN_TIMEOUT_EN
          moves_d     = moves_q + 1'b1;
`endif
        end
      end
      S_SETTLE: begin
        if (tmr_q == TW'(SETTLE_CYCLES - 1)) state_d = S_MOVE;
        else                                 tmr_d   = tmr_q + 1'b1;
      end
      S_SPARK: begin
        if (tmr_q == TW'(SPARK_CYCLES - 1)) state_d = S_DONE;
        else                                tmr_d   = tmr_q + 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    spark_d = (state_d == S_SPARK);
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      ack_d[j] = (state_d == S_DONE) && (grant_d == ID_W'(j));
    end
    if (state_d == S_IDLE) grant_d = '0;
  end

  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      tgt_q   <= '0;
      tmr_q   <= '0;
      busy_q  <= 1'b0;
      spark_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      tgt_q   <= tgt_d;
      tmr_q   <= tmr_d;
      busy_q  <= busy_d;
      spark_q <= spark_d;
      ack_q   <= ack_d;
    end
  end

`ifdef IGN_TIMEOUT_EN
  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      moves_q <= '0;
      err_q   <= 1'b0;
    end else begin
      moves_q <= moves_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign req_ack  = ack_q;
  assign spark    = spark_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule
